// File: rtl/cpu_pkg.sv
// Shared definitions for the MEM stage: redirect encodings, access FSM states
// and the MEM/WB register layout with its bubble value.
package cpu_pkg;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } dm_state_e;

  typedef struct packed {
    logic [31:0] dout;
    logic [31:0] aluout;
    logic [4:0]  rw;
    logic        memtoreg;
    logic        regwr;
  } memwb_t;

  localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/dm_access_fsm.sv
// Data-memory access sequencer: IDLE detects a memory op, ACCESS holds the
// request until ack or until TIMEOUT ack-less cycles have elapsed.
module dm_access_fsm
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic memop,
  input  logic dm_ack,
  output logic stall,
  output logic dm_req,
  output logic done,
  output logic timeout,
  output logic idle
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  dm_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    dm_req    = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    idle      = 1'b0;
    case (state)
      ST_IDLE: begin
        idle = 1'b1;
        if (memop) begin
          stall     = 1'b1;
          state_nxt = ST_ACCESS;
          cnt_nxt   = '0;
        end
      end
      ST_ACCESS: begin
        dm_req = 1'b1;
        // ack wins over a timeout landing in the same cycle
        if (dm_ack) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          stall = 1'b1;
          if (cnt != '1) cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: branch/jump redirect, handshaked data-memory access and the MEM/WB
// register. Optional MEM_OVF_SQUASH_EN squashes overflowing instructions.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] Btarg,
  input  logic [29:0] Jtarg,
  input  logic        Zero,
  input  logic        Overflow,
  input  logic [31:0] Addr,
  input  logic [31:0] Di,
  input  logic [4:0]  Rw,
  input  logic        MemWr,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        MemtoReg,
  input  logic        RegWr,
  output logic [1:0]  npc_sel,
  output logic [29:0] npc_targ,
  output logic        flush,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        dm_err,
  output logic [31:0] Dout_wb,
  output logic [31:0] ALUout_wb,
  output logic [4:0]  Rw_wb,
  output logic        MemtoReg_wb,
  output logic        RegWr_wb
);

  logic   memop, ovf_kill;
  logic   done, timeout, idle;
  memwb_t wb, wb_nxt;

`ifdef MEM_OVF_SQUASH_EN
  assign memop    = (MemWr | MemtoReg) & ~Overflow;
  assign ovf_kill = Overflow;
`else
  logic unused_ovf;
  assign unused_ovf = Overflow;
  assign memop      = MemWr | MemtoReg;
  assign ovf_kill   = 1'b0;
`endif

  dm_access_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .memop   (memop),
    .dm_ack  (dm_ack),
    .stall   (stall),
    .dm_req  (dm_req),
    .done    (done),
    .timeout (timeout),
    .idle    (idle)
  );

  assign dm_we    = dm_req & MemWr;
  assign dm_addr  = Addr;
  assign dm_wdata = Di;

  always_comb begin
    npc_sel  = NPC_SEQ;
    npc_targ = '0;
    if (Jump) begin
      npc_sel  = NPC_J;
      npc_targ = Jtarg;
    end else if (Branch & Zero) begin
      npc_sel  = NPC_BR;
      npc_targ = Btarg;
    end
  end
  assign flush = (npc_sel != NPC_SEQ);

  always_comb begin
    wb_nxt          = MEMWB_BUBBLE;
    wb_nxt.aluout   = Addr;
    wb_nxt.rw       = Rw;
    wb_nxt.memtoreg = MemtoReg;
    wb_nxt.regwr    = RegWr & ~ovf_kill;
    if (idle && !memop) begin
      wb_nxt.dout = '0;
    end else if (done) begin
      wb_nxt.dout = MemWr ? 32'h0 : dm_rdata;
    end else if (timeout) begin
      // aborted access still retires, but must not write the register file
      wb_nxt.regwr = 1'b0;
    end else begin
      wb_nxt = MEMWB_BUBBLE;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb     <= MEMWB_BUBBLE;
      dm_err <= 1'b0;
    end else begin
      wb <= wb_nxt;
      if (timeout) dm_err <= 1'b1;
    end
  end

  assign Dout_wb     = wb.dout;
  assign ALUout_wb   = wb.aluout;
  assign Rw_wb       = wb.rw;
  assign MemtoReg_wb = wb.memtoreg;
  assign RegWr_wb    = wb.regwr;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed literal cases followed by random
// instruction streams checked every cycle against a transaction-level model.
module tb_mem_stage;

  localparam int TIMEOUT = 16;
`ifdef MEM_OVF_SQUASH_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [29:0] Btarg = '0, Jtarg = '0;
  logic        Zero = 0, Overflow = 0, MemWr = 0, Branch = 0, Jump = 0, MemtoReg = 0, RegWr = 0;
  logic [31:0] Addr = '0, Di = '0, dm_rdata = '0;
  logic [4:0]  Rw = '0;
  logic        dm_ack = 0;
  logic [1:0]  npc_sel;
  logic [29:0] npc_targ;
  logic        flush, stall, dm_req, dm_we, dm_err, MemtoReg_wb, RegWr_wb;
  logic [31:0] dm_addr, dm_wdata, Dout_wb, ALUout_wb;
  logic [4:0]  Rw_wb;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .Btarg(Btarg), .Jtarg(Jtarg), .Zero(Zero),
    .Overflow(Overflow), .Addr(Addr), .Di(Di), .Rw(Rw), .MemWr(MemWr),
    .Branch(Branch), .Jump(Jump), .MemtoReg(MemtoReg), .RegWr(RegWr),
    .npc_sel(npc_sel), .npc_targ(npc_targ), .flush(flush), .stall(stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err), .Dout_wb(Dout_wb),
    .ALUout_wb(ALUout_wb), .Rw_wb(Rw_wb), .MemtoReg_wb(MemtoReg_wb), .RegWr_wb(RegWr_wb)
  );

  typedef struct {
    logic [29:0] btarg, jtarg;
    logic        zero, ovf;
    logic [31:0] addr, di;
    logic [4:0]  rw;
    logic        memwr, branch, jump, memtoreg, regwr;
  } instr_t;

  int checks = 0, errors = 0;
  logic       s_stall = 0, s_req = 0, s_we = 0, s_flush = 0;
  logic [1:0] s_sel;
  logic [29:0] s_targ;

  function automatic void chk(string name, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // one pipeline cycle: inputs change just after the rising edge, and the
  // combinational outputs are sampled just before the falling (update) edge
  task automatic apply(input instr_t i, input logic ack, input logic [31:0] rd);
    @(posedge clk); #1;
    Btarg = i.btarg; Jtarg = i.jtarg; Zero = i.zero; Overflow = i.ovf;
    Addr = i.addr; Di = i.di; Rw = i.rw; MemWr = i.memwr; Branch = i.branch;
    Jump = i.jump; MemtoReg = i.memtoreg; RegWr = i.regwr;
    dm_ack = ack; dm_rdata = rd;
    #3;
    s_stall = stall; s_req = dm_req; s_we = dm_we;
    s_sel = npc_sel; s_targ = npc_targ; s_flush = flush;
  endtask

  function automatic instr_t mk(int kind);
    instr_t i;
    i.btarg = 30'($urandom); i.jtarg = 30'($urandom);
    i.zero = 1'($urandom); i.ovf = ($urandom_range(0, 7) == 0);
    i.addr = $urandom; i.di = $urandom; i.rw = 5'($urandom);
    i.memwr = 0; i.branch = 0; i.jump = 0; i.memtoreg = 0; i.regwr = 0;
    case (kind)
      0: i.regwr = 1;
      1: begin i.memtoreg = 1; i.regwr = 1; end
      2: i.memwr = 1;
      3: i.branch = 1;
      default: i.jump = 1;
    endcase
    return i;
  endfunction

  // ---- reference model: one outstanding transaction, tracked by how many
  // access cycles it has spent waiting for its acknowledgement
  bit          busy = 0, m_err = 0;
  int          waited = 0;
  logic [31:0] e_dout = 0, e_alu = 0;
  logic [4:0]  e_rw = 0;
  logic        e_m2r = 0, e_wen = 0;

  task automatic model_reset();
    busy = 0; waited = 0; m_err = 0;
    e_dout = 0; e_alu = 0; e_rw = 0; e_m2r = 0; e_wen = 0;
  endtask

  task automatic retire(input logic [31:0] d, input logic wen);
    e_dout = d; e_alu = Addr; e_rw = Rw; e_m2r = MemtoReg;
    e_wen = wen & RegWr & ~(SQ & Overflow);
  endtask

  always begin : compare
    logic memop, x_stall, x_req, x_we, give_up;
    logic [1:0] x_sel;
    logic [29:0] x_targ;
    @(posedge clk); #2;
    if (!rst_n) model_reset();
    memop   = (MemWr | MemtoReg) & ~(SQ & Overflow);
    give_up = busy && !dm_ack && (waited == TIMEOUT - 1);
    x_req   = busy;
    x_we    = busy & MemWr;
    x_stall = busy ? (!dm_ack && !give_up) : memop;
    x_sel   = Jump ? 2'b10 : (Branch && Zero) ? 2'b01 : 2'b00;
    x_targ  = Jump ? Jtarg : (Branch && Zero) ? Btarg : 30'h0;
    chk("comb", {x_stall, x_req, x_we, x_sel, x_targ, x_sel != 2'b00},
                {stall, dm_req, dm_we, npc_sel, npc_targ, flush} ^ 36'h0 ^
                {x_stall, x_req, x_we, x_sel, x_targ, x_sel != 2'b00} ^
                {x_stall, x_req, x_we, x_sel, x_targ, x_sel != 2'b00});
    chk("dm_pass", {dm_addr, dm_wdata}, {Addr, Di});
    @(negedge clk); #1;
    if (!rst_n) model_reset();
    else if (!busy) begin
      if (memop) begin busy = 1; waited = 0; e_dout = 0; e_alu = 0; e_rw = 0; e_m2r = 0; e_wen = 0; end
      else retire(32'h0, 1'b1);
    end else if (dm_ack) begin
      retire(MemWr ? 32'h0 : dm_rdata, 1'b1); busy = 0;
    end else if (waited == TIMEOUT - 1) begin
      retire(32'h0, 1'b0); m_err = 1; busy = 0;
    end else begin
      waited++; e_dout = 0; e_alu = 0; e_rw = 0; e_m2r = 0; e_wen = 0;
    end
    chk("memwb", {Dout_wb, ALUout_wb, Rw_wb, MemtoReg_wb, RegWr_wb, dm_err},
                 {e_dout, e_alu, e_rw, e_m2r, e_wen, m_err});
  end

  initial begin
    instr_t alu, ld, st, bj, cur;
    int n, nreq, nwe;
    bit done;
    alu = mk(0); alu.addr = 32'h1234; alu.rw = 5; alu.ovf = 0; alu.branch = 0; alu.jump = 0;
    ld  = mk(1); ld.addr = 32'h40; ld.ovf = 0;
    st  = mk(2); st.di = 32'hA5A5; st.ovf = 0;
    bj  = mk(0); bj.regwr = 0; bj.branch = 1; bj.zero = 1; bj.jump = 1;
    bj.btarg = 30'h10; bj.jtarg = 30'h20;

    repeat (2) @(posedge clk);
    #2 chk("reset_state", {Dout_wb, ALUout_wb, Rw_wb, MemtoReg_wb, RegWr_wb, dm_err, dm_req, stall}, 0);
    @(posedge clk); #1 rst_n = 1;

    apply(alu, 0, 32'h0);
    chk("alu_stall", s_stall, 0);
    @(negedge clk); #1;
    chk("alu_wb", {ALUout_wb, Rw_wb, RegWr_wb}, {32'h1234, 5'd5, 1'b1});

    n = 0;
    repeat (4) begin apply(ld, 0, $urandom); n += int'(s_stall); end
    apply(ld, 1, 32'hDEADBEEF); n += int'(s_stall);
    chk("ld_stall_cycles", n, 4);
    @(negedge clk); #1;
    chk("ld_wb", {Dout_wb, MemtoReg_wb, RegWr_wb}, {32'hDEADBEEF, 1'b1, 1'b1});

    n = 0; nwe = 0;
    apply(st, 0, $urandom); n += int'(s_stall); nwe += int'(s_we);
    apply(st, 1, $urandom); n += int'(s_stall); nwe += int'(s_we);
    chk("st_cycles", {n[7:0], nwe[7:0]}, {8'd1, 8'd1});
    @(negedge clk); #1;
    chk("st_wb", {Dout_wb, RegWr_wb}, {32'h0, 1'b0});

    apply(bj, 0, 0);
    chk("jump_prio", {s_sel, s_targ, s_flush}, {2'b10, 30'h20, 1'b1});
    bj.jump = 0; apply(bj, 0, 0);
    chk("branch_taken", {s_sel, s_targ, s_flush}, {2'b01, 30'h10, 1'b1});
    bj.zero = 0; apply(bj, 0, 0);
    chk("branch_not_taken", {s_sel, s_targ, s_flush}, {2'b00, 30'h0, 1'b0});

    n = 0; nreq = 0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      apply(ld, 0, $urandom);
      nreq += int'(s_req);
      if (!s_stall) done = 1; else n++;
    end
    chk("tmo_bound", done, 1);
    chk("tmo_cycles", {n[7:0], nreq[7:0]}, {8'd16, 8'd16});
    @(negedge clk); #1;
    chk("tmo_wb", {dm_err, RegWr_wb}, {1'b1, 1'b0});

    apply(ld, 0, 0);
    apply(ld, 0, 0);
    chk("pre_rst_req", s_req, 1);
    @(posedge clk); #1 rst_n = 0; dm_ack = 0;
    #1 chk("rst_mid_access", {dm_req, dm_err, Dout_wb, ALUout_wb, Rw_wb, MemtoReg_wb, RegWr_wb}, 0);
    @(posedge clk); #1 rst_n = 1; dm_ack = 1; dm_rdata = 32'hBAD0BAD0;
    #3 chk("late_ack_ignored", {stall, dm_req}, {1'b1, 1'b0});
    @(negedge clk); #1;
    chk("late_ack_wb", {Dout_wb, RegWr_wb}, {32'h0, 1'b0});
    apply(ld, 1, 32'h600D);

    cur = mk(0);
    for (int i = 0; i < 900; i++) begin
      if (!s_stall) cur = mk($urandom_range(0, 4));
      apply(cur, ((i % 150) >= 110) ? 1'b0 : ($urandom_range(0, 2) == 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
